// File: rtl/dl_selftest_if.sv
// Handshake/bus bundle between the D-latch self-test engine and its user/latch.
// Pure wiring, no latency.
// No backpressure: all signals are level-sampled by the receiving side.
interface dl_selftest_if;
  logic       start;
  logic       d_out;
  logic       e_out;
  logic       q_in;
  logic       qb_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_count;
  logic [3:0] fail_idx;
  logic       fail_valid;

  // Controller / board side: issues start, returns the latch outputs.
  modport master (
    output start, q_in, qb_in,
    input  d_out, e_out, busy, done, pass, err_count, fail_idx, fail_valid
  );

  // Self-test engine side.
  modport slave (
    input  start, q_in, qb_in,
    output d_out, e_out, busy, done, pass, err_count, fail_idx, fail_valid
  );
endinterface

// File: rtl/dl_selftest.sv
// On-chip self-test of a D latch: plays a 10-vector {D,E} ROM and checks Q/Qb.
// Latency: SETTLE+1 cycles per vector, done 10*(SETTLE+1) edges after start.
// No backpressure: start is ignored while busy; latch drive is open-loop.
module dl_selftest #(
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  dl_selftest_if.slave tst
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter reload value; the SETTLE state spends this many extra cycles
  // counting down to 0, then one cycle in CHECK, giving SETTLE+1 per vector.
  localparam logic [7:0] CNT_LOAD = 8'(SETTLE - 1);
  localparam logic [3:0] LAST_IDX = 4'd9;

  // Vector ROM, {D, E} per index.
  function automatic logic [1:0] rom_f(input logic [3:0] idx);
    logic [1:0] v;
    case (idx)
      4'd0:    v = 2'b00;
      4'd1:    v = 2'b01;
      4'd2:    v = 2'b00;
      4'd3:    v = 2'b10;
      4'd4:    v = 2'b11;
      4'd5:    v = 2'b00;
      4'd6:    v = 2'b01;
      4'd7:    v = 2'b00;
      4'd8:    v = 2'b11;
      4'd9:    v = 2'b10;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

  localparam logic [1:0] VEC0 = 2'b00;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [7:0] cnt_q;
  logic       d_q;
  logic       e_q;
  logic       model_q;
  logic       model_valid_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [3:0] err_q;
  logic [3:0] fail_idx_q;
  logic       fail_valid_q;

  logic [3:0] nxt_idx_d;
  logic [1:0] nxt_vec_d;
  logic       vec_fail_d;
  logic [3:0] err_d;

  // Next vector fetch and the pass/fail decision for the vector being held.
  always_comb begin
    nxt_idx_d  = idx_q + 4'd1;
    nxt_vec_d  = rom_f(nxt_idx_d);
    // One failure per vector regardless of whether Q, Qb or both are wrong;
    // nothing is checked until the model has seen an enabled vector.
    vec_fail_d = model_valid_q &&
                 ((tst.q_in != model_q) || (tst.qb_in != ~model_q));
    err_d      = err_q;
    if (vec_fail_d && (err_q != 4'hF)) begin
      err_d = err_q + 4'd1;
    end
  end

  // Control FSM with registered drive, model and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= 4'd0;
      cnt_q         <= 8'd0;
      d_q           <= 1'b0;
      e_q           <= 1'b0;
      model_q       <= 1'b0;
      model_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      err_q         <= 4'd0;
      fail_idx_q    <= 4'd0;
      fail_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (tst.start) begin
            idx_q         <= 4'd0;
            d_q           <= VEC0[1];
            e_q           <= VEC0[0];
            // Model starts cleared and then sees vector 0 like any other.
            model_q       <= VEC0[0] ? VEC0[1] : 1'b0;
            model_valid_q <= VEC0[0];
            cnt_q         <= CNT_LOAD;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= 4'd0;
            fail_idx_q    <= 4'd0;
            fail_valid_q  <= 1'b0;
            state_q       <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (cnt_q == 8'd0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        S_CHECK: begin
          err_q <= err_d;
          if (vec_fail_d && !fail_valid_q) begin
            fail_idx_q   <= idx_q;
            fail_valid_q <= 1'b1;
          end
          if (idx_q < LAST_IDX) begin
            idx_q <= nxt_idx_d;
            d_q   <= nxt_vec_d[1];
            e_q   <= nxt_vec_d[0];
            if (nxt_vec_d[0]) begin
              model_q       <= nxt_vec_d[1];
              model_valid_q <= 1'b1;
            end
            cnt_q   <= CNT_LOAD;
            state_q <= S_SETTLE;
          end else begin
            // Last vector: drive stays on vector 9 while DONE is held.
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 4'd0);
            state_q <= S_DONE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tst.d_out      = d_q;
  assign tst.e_out      = e_q;
  assign tst.busy       = busy_q;
  assign tst.done       = done_q;
  assign tst.pass       = pass_q;
  assign tst.err_count  = err_q;
  assign tst.fail_idx   = fail_idx_q;
  assign tst.fail_valid = fail_valid_q;

endmodule
